// File: rtl/scpu_io_arbiter.sv
// Round-robin share of the SCPU ext_in/ext_out byte pair; grant HOLD cycles, then capture and done pulse.
// Latency HOLD+2 cycles per transaction; waiting requesters stall on their req level, nothing is dropped.
module scpu_io_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         HOLD     = 8,
  parameter logic [7:0] IDLE_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [7:0]          rsp_data,
  output logic [7:0]          cpu_in,
  input  logic [7:0]          cpu_out,
  output logic                busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic [7:0]      rsp_nxt, cpu_in_nxt, win_byte;
  logic [PW:0]     idx;
  logic [PW-1:0]   win;
  logic            found;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NREQ; k++)
      if (win == PW'(k)) win_byte = req_data[8*k +: 8];
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    rsp_nxt    = rsp_data;
    cpu_in_nxt = cpu_in;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt    = NREQ'(1) << win;
          cpu_in_nxt = win_byte;
          cnt_nxt    = CW'(HOLD - 1);
          ptr_nxt    = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          state_nxt  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          // gnt still holds the owner, so it doubles as the done vector.
          rsp_nxt    = cpu_out;
          done_nxt   = gnt;
          gnt_nxt    = '0;
          cpu_in_nxt = IDLE_VAL;
          state_nxt  = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      rsp_data <= 8'h00;
      cpu_in   <= IDLE_VAL;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      rsp_data <= rsp_nxt;
      cpu_in   <= cpu_in_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_scpu_io_arbiter.sv
// Bench for scpu_io_arbiter: HOLD=8 and HOLD=1 instances share stimulus, each checked every cycle against a timeline model.
module tb_scpu_io_arbiter;

  localparam int NREQ = 4;
  localparam int HA   = 8;
  localparam int HB   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  cpu_out;
  logic [3:0]  gnt_a, done_a, gnt_b, done_b;
  logic [7:0]  rsp_a, cin_a, rsp_b, cin_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  scpu_io_arbiter #(.NREQ(NREQ), .HOLD(HA), .IDLE_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt_a), .done(done_a),
    .rsp_data(rsp_a), .cpu_in(cin_a), .cpu_out(cpu_out), .busy(busy_a));

  scpu_io_arbiter #(.NREQ(NREQ), .HOLD(HB), .IDLE_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt_b), .done(done_b),
    .rsp_data(rsp_b), .cpu_in(cin_b), .cpu_out(cpu_out), .busy(busy_b));

  // A transaction is a grant edge t0; everything else follows from elapsed edges.
  typedef struct {
    bit         active;
    int         t0;
    int         w;
    logic [7:0] byt;
    int         ptr;
    logic [7:0] rsp;
  } mdl_t;

  mdl_t ma, mb;
  int   n;
  int   vec;
  int   errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic mdl_t step(mdl_t s, int hold, int en, logic r_st, logic [3:0] r,
                                logic [31:0] rd, logic [7:0] co);
    bit hit;
    if (r_st) begin
      s.active = 0;
      s.ptr    = 0;
      s.rsp    = 8'h00;
      return s;
    end
    if (s.active) begin
      if (en == s.t0 + hold)     s.rsp    = co;
      if (en == s.t0 + hold + 1) s.active = 0;
    end else if (r != 0) begin
      hit = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (s.ptr + k) % NREQ;
        if (!hit && r[i]) begin
          hit = 1;
          s.w = i;
        end
      end
      s.active = 1;
      s.t0     = en;
      s.byt    = rd[8*s.w +: 8];
      s.ptr    = (s.w + 1) % NREQ;
    end
    return s;
  endfunction

  task automatic cmp(input string nm, input mdl_t s, input int hold, input logic [3:0] g,
                     input logic [3:0] d, input logic [7:0] rs, input logic [7:0] ci, input logic b);
    logic [3:0] eg, ed;
    logic [7:0] eci;
    logic       eb;
    eg = 4'b0; ed = 4'b0; eci = 8'h00; eb = 1'b0;
    if (s.active) begin
      eb = 1'b1;
      if (n - s.t0 < hold) begin
        eg  = 4'b1 << s.w;
        eci = s.byt;
      end else begin
        ed = 4'b1 << s.w;
      end
    end
    chk({nm, ".gnt"}, 32'(g), 32'(eg));
    chk({nm, ".done"}, 32'(d), 32'(ed));
    chk({nm, ".rsp_data"}, 32'(rs), 32'(s.rsp));
    chk({nm, ".cpu_in"}, 32'(ci), 32'(eci));
    chk({nm, ".busy"}, 32'(b), 32'(eb));
  endtask

  // Inputs change only after the negedge check, so the model sees what the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    n++;
    ma = step(ma, HA, n, rst, req, req_data, cpu_out);
    mb = step(mb, HB, n, rst, req, req_data, cpu_out);
    @(negedge clk);
    cmp("a", ma, HA, gnt_a, done_a, rsp_a, cin_a, busy_a);
    cmp("b", mb, HB, gnt_b, done_b, rsp_b, cin_b, busy_b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    vec = 0; errs = 0; n = 0;
    rst = 1'b1; req = 4'b0; req_data = 32'h0; cpu_out = 8'h00;
    repeat (2) cycle();
    chk("rst.gnt", 32'(gnt_a), 32'h0);
    chk("rst.cpu_in", 32'(cin_a), 32'h0);
    rst = 1'b0;
    cycle();

    // Single request from 2; response captured on the HOLD-th edge.
    req = 4'b0100; req_data = 32'h000F_0000; cpu_out = 8'hA5;
    cycle();
    chk("t1.gnt", 32'(gnt_a), 32'h4);
    chk("t1.cpu_in", 32'(cin_a), 32'h0F);
    req = 4'b0;
    repeat (HA) cycle();
    chk("t1.done", 32'(done_a), 32'h4);
    chk("t1.rsp", 32'(rsp_a), 32'hA5);
    chk("t1.cpu_in_idle", 32'(cin_a), 32'h0);
    repeat (3) cycle();

    // All four continuously from reset: rotation 0,1,2,3,0.
    do_reset();
    req = 4'hF; req_data = 32'h4433_2211;
    for (int t = 0; t < 5; t++) begin
      cycle();
      chk("rr.gnt", 32'(gnt_a), 32'(4'b1 << (t % 4)));
      cpu_out = 8'(8'h30 + t);
      repeat (HA + 1) cycle();
    end
    req = 4'b0;
    repeat (12) cycle();

    // Requester 1 drops req and changes data mid-DRIVE.
    do_reset();
    req = 4'b0010; req_data = 32'h0000_5A00; cpu_out = 8'h3C;
    cycle();
    req = 4'b0; req_data = 32'h0000_C300;
    repeat (3) cycle();
    chk("t3.cpu_in", 32'(cin_a), 32'h5A);
    repeat (HA - 3) cycle();
    chk("t3.done", 32'(done_a), 32'h2);
    repeat (3) cycle();

    // Reset on the 4th DRIVE cycle; transaction lost, then 3 served from ptr=0.
    req = 4'b0001; req_data = 32'h0000_0077;
    cycle();
    req = 4'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("t4.done", 32'(done_a), 32'h0);
    chk("t4.gnt", 32'(gnt_a), 32'h0);
    rst = 1'b0;
    cycle();
    chk("t4.no_done", 32'(done_a), 32'h0);
    req = 4'b1000; req_data = 32'h9900_0000; cpu_out = 8'h66;
    cycle();
    chk("t4.regnt", 32'(gnt_a), 32'h8);
    req = 4'b0;
    repeat (HA + 2) cycle();

    // Grant to 2 leaves ptr=3; 0 and 3 together -> 3 first.
    do_reset();
    req = 4'b0100; req_data = 32'h0102_0304;
    cycle();
    req = 4'b0;
    repeat (HA + 1) cycle();
    req = 4'b1001;
    cycle();
    chk("t6.gnt3", 32'(gnt_a), 32'h8);
    repeat (HA + 2) cycle();
    chk("t6.gnt0", 32'(gnt_a), 32'h1);
    req = 4'b0;
    repeat (HA + 2) cycle();

    // Lone requester held high: back-to-back service (HOLD=1 -> every 3 cycles).
    do_reset();
    req = 4'b0001;
    repeat (24) cycle();
    req = 4'b0;
    repeat (12) cycle();

    // Random traffic with occasional resets.
    for (int t = 0; t < 4000; t++) begin
      rst      = ($urandom_range(0, 249) == 0);
      req      = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      req_data = $urandom;
      cpu_out  = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/scpu_io_arbiter.md
# scpu_io_arbiter

Round-robin arbiter that shares the SCPU's single 8-bit external I/O pair (`ext_in`/`ext_out`) between NREQ requesters. A granted requester's byte is driven onto the CPU input for a fixed number of cycles. The CPU output is then captured and returned with a one-cycle done pulse. It sits between the SCPU top-level I/O and the peripheral/test-harness agents that want to exchange bytes with the running program.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; range 2..8.
- `HOLD`, 8: cycles `cpu_in` is held before `cpu_out` is sampled; must be >= 1.
- `IDLE_VAL`, 8'h00: value driven on `cpu_in` when no transaction is active.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input NREQ: per-requester request level.
- `req_data` input 8*NREQ: byte of requester i at bits [8i+7:8i].
- `gnt` output NREQ: one-hot grant; high for the whole DRIVE state.
- `done` output NREQ: one-hot, one-cycle pulse when the response is valid.
- `rsp_data` output 8: captured `cpu_out`; valid while `done` is high, held until the next capture.
- `cpu_in` output 8: connects to SCPU `ext_in`.
- `cpu_out` input 8: connects from SCPU `ext_out`.
- `busy` output 1: high in DRIVE and RELEASE.

## Operation
- States: IDLE, DRIVE, RELEASE.
- IDLE:
  - If any `req` bit is high at a clock edge, select the winner `w` by round-robin. Search starts at `ptr` and goes upward, wrapping modulo NREQ.
  - On that edge: `gnt[w]`<=1, `cpu_in`<=`req_data[w]` (latched, sampled only on this edge), `cnt`<=HOLD-1, `ptr`<=(w+1) mod NREQ, state<=DRIVE.
  - If no request is present: remain in IDLE, `cpu_in`=IDLE_VAL.
- DRIVE:
  - While `cnt`!=0: `cnt` decrements.
  - On the edge with `cnt`==0: `rsp_data`<=`cpu_out`, `done[w]`<=1, `gnt`<=0, `cpu_in`<=IDLE_VAL, state<=RELEASE.
- RELEASE: lasts one cycle with no arbitration. `done` clears on the exit edge and state<=IDLE.
- Requests are levels:
  - A requester must drop `req` during its `done` cycle. If it is still high at the next IDLE edge, that counts as a new request.
  - Changes to the granted requester's `req` or `req_data` during DRIVE are ignored. Transactions are never aborted.
- `ptr` is advanced only by a grant. A lone requester is therefore served back-to-back.
- `cnt` width is clog2(HOLD+1). There is no wrap; it only counts down from HOLD-1 to 0.

## Timing
- Reset values (applied on the edge with `rst`=1, overriding everything): state=IDLE, `gnt`=0, `done`=0, `rsp_data`=8'h00, `cpu_in`=IDLE_VAL, `busy`=0, `ptr`=0, `cnt`=0.
- Reset mid-transaction: all of the above apply on the next edge. No `done` pulse is issued and the in-flight transaction is lost.
- Request sampled at edge E0:
  - `gnt`/`cpu_in` are valid after E0.
  - `cpu_out` is sampled at edge E_HOLD.
  - `done` is high from E_HOLD to E_HOLD+1.
  - State returns to IDLE after E_HOLD+1.
  - Earliest next grant is at E_HOLD+2.
  - Period per transaction is HOLD+2 cycles.
- Simultaneous requests: exactly one grant. After reset the priority order is 0,1,...,NREQ-1, rotating thereafter.
- A request arriving during DRIVE/RELEASE waits and is considered at the first IDLE edge.
- `gnt` and `done` are never high in the same cycle. At most one bit of each is ever set.

## Test plan
- Single request, NREQ=4, HOLD=8, req[2]=1, req_data[2]=8'h0F, cpu_out=8'hA5 at capture -> gnt=4'b0100 for 8 cycles, `cpu_in`=8'h0F, then done=4'b0100 for 1 cycle with rsp_data=8'hA5, and `cpu_in` returns to 8'h00.
- All four requesting continuously after reset -> grants in order 0,1,2,3,0, each HOLD+2=10 cycles apart.
- req[1] dropped and req_data[1] changed mid-DRIVE -> `cpu_in` keeps the latched byte, and `done[1]` still pulses at the expected cycle.
- `rst` asserted on the 4th DRIVE cycle -> next cycle all outputs are at reset values, with no `done` pulse. Re-request req[3] -> served normally, and ptr=0 ordering is observed.
- HOLD=1 with req[0] held high continuously -> gnt high 1 cycle, done 1 cycle, a new grant every 3 cycles.
- req[0] and req[3] asserted at the same edge right after a grant to 2 (ptr=3) -> requester 3 is served before 0.
